// File: rtl/rw_pkg.sv
// Shared types and defaults for the read/write command engine.
//   state_t   : command FSM state encoding
//   DW_DEF    : default data width
//   DEPTH_DEF : default storage depth in words
//   CNT_W     : width of the read-latency down-counter
package rw_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        RWAIT = 2'd2,
        RDATA = 2'd3
    } state_t;

endpackage

// File: rtl/rw_mem.sv
// DEPTH x DW storage with one write port and one registered-address read port.
//   clock  : write and address-register clock
//   reset  : asynchronous active-high reset of the read-address register only
//   we     : write enable; wdata is stored at mem[waddr] on the clock edge
//   waddr  : write address
//   wdata  : write data
//   re     : load raddr into the read-address register
//   raddr  : read address to latch
//   rdata  : mem[latched read address], combinational from current contents
module rw_mem
    import rw_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;

    // Contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raddr_q <= '0;
        end else if (re) begin
            raddr_q <= raddr;
        end
    end

    // Reading through the latched address means a write landing while a read
    // is waiting is visible when the data is finally presented.
    assign rdata = mem[raddr_q];

endmodule

// File: rtl/rw_cmd_engine.sv
// Read/write command engine in front of a small synchronous memory.
//   clock    : sole clock, all state updates on posedge
//   reset    : asynchronous active-high reset
//   read     : read command strobe
//   write    : write command strobe
//   addr     : command address
//   wdata    : write data
//   ready    : command-completion pulse (write ack cycle or read data cycle)
//   rvalid   : read data valid, one-cycle pulse
//   rdata    : read data, held between reads
//   busy     : high while a read is waiting for its latency to elapse
//   err      : sticky flag, set when read and write are asserted together
//   drop_cnt : saturating count of commands refused while busy
module rw_cmd_engine
    import rw_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned READ_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic                     ready,
    output logic                     rvalid,
    output logic [DW-1:0]            rdata,
    output logic                     busy,
    output logic                     err,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    // RWAIT lasts counter+1 cycles, so the load value is two less than the
    // latency (one cycle is the accepting edge, one is the RDATA cycle).
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (READ_LAT > 1) ? CNT_W'(READ_LAT - 2) : '0;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             mem_we;
    logic             mem_re;
    logic [DW-1:0]    mem_rdata;
    logic [DW-1:0]    rdata_q;
    logic             err_set;
    logic             drop;

    rw_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .waddr (addr),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        err_set    = 1'b0;
        drop       = 1'b0;

        unique case (state)
            RWAIT: begin
                // Commands are refused here; the read keeps counting down.
                drop    = read | write;
                err_set = read & write;
                if (cnt == '0) begin
                    state_next = RDATA;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                // IDLE, ACK and RDATA all accept a new command.
                if (read && write) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (write) begin
                    mem_we     = 1'b1;
                    state_next = ACK;
                end else if (read) begin
                    mem_re = 1'b1;
                    if (READ_LAT == 1) begin
                        state_next = RDATA;
                    end else begin
                        state_next = RWAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q  <= '0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (state == RDATA) begin
                rdata_q <= mem_rdata;
            end
            if (err_set) begin
                err <= 1'b1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign ready  = (state == ACK) || (state == RDATA);
    assign rvalid = (state == RDATA);
    assign busy   = (state == RWAIT);
    // Live memory value during the data cycle, last presented value otherwise.
    assign rdata  = rvalid ? mem_rdata : rdata_q;

endmodule

// File: doc/rw_cmd_engine.md
RW_CMD_ENGINE -- requirements
Module: rw_cmd_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of storage words.
REQ-002 SHALL have parameter DW, default 8, data width in bits.
REQ-003 SHALL have parameter READ_LAT, default 2, legal range 1..7, cycles from read acceptance to rvalid.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port read  input  1  read command strobe.
REQ-007 SHALL have port write  input  1  write command strobe.
REQ-008 SHALL have port addr  input  $clog2(DEPTH)  command address.
REQ-009 SHALL have port wdata  input  DW  write data.
REQ-010 SHALL have port ready  output  1  command-completion pulse.
REQ-011 SHALL have port rvalid  output  1  read data valid, one-cycle pulse.
REQ-012 SHALL have port rdata  output  DW  read data.
REQ-013 SHALL have port busy  output  1  high while a read is in flight (commands are refused).
REQ-014 SHALL have port err  output  1  sticky protocol-violation flag.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of refused commands.

Function
REQ-016 SHALL implement FSM states IDLE, ACK, RWAIT, RDATA.
REQ-017 SHALL accept commands only in IDLE, ACK or RDATA ("accepting" states).
REQ-018 In an accepting state, write=1 and read=0 at edge t SHALL store wdata at mem[addr] at edge t and enter ACK.
REQ-019 ready SHALL be 1 throughout every cycle in ACK, so that each accepted write gives ready=1 in the following cycle (write |=> ready), including for back-to-back writes.
REQ-020 In an accepting state, read=1 and write=0 at edge t SHALL latch addr, and enter RDATA if READ_LAT=1, else enter RWAIT with down-counter loaded to READ_LAT-2.
REQ-021 In RWAIT, when the counter is 0 the FSM SHALL enter RDATA; otherwise the counter SHALL decrement.
REQ-022 In RDATA, rvalid=1 and ready=1 SHALL hold for exactly one cycle, with rdata equal to mem[latched addr] as of that cycle.
REQ-023 rvalid SHALL therefore first be high READ_LAT cycles after the accepting edge.
REQ-024 rdata SHALL hold its last value while rvalid=0.
REQ-025 read=1 and write=1 together SHALL execute neither command, set err (sticky until reset), and leave the state unchanged except that ACK or RDATA returns to IDLE.
REQ-026 Any read or write seen while in RWAIT SHALL be refused: no memory change, drop_cnt incremented, with saturation at 255.
REQ-027 An accepting state with no command SHALL go to IDLE.
REQ-028 busy SHALL be 1 exactly when state is RWAIT.
REQ-029 A read issued in the cycle after a write to the same address SHALL return the new data.

Reset
REQ-030 While reset=1, the block SHALL hold state=IDLE, ready=0, rvalid=0, rdata=0, busy=0, err=0, drop_cnt=0, counter=0, independent of clock.
REQ-031 Reset asserted during RWAIT or RDATA SHALL abort the read; no rvalid SHALL follow.
REQ-032 Memory contents SHALL NOT be reset; reads of never-written addresses return undefined data.

Structure
REQ-033 Package rw_pkg SHALL hold the state enum type, the DW and DEPTH defaults, and the counter width constant (3 bits).
REQ-034 Storage SHALL be a sub-module rw_mem: one write port and one registered-address read port, DEPTH x DW.
REQ-035 FSM, counter, err and drop_cnt logic SHALL reside in rw_cmd_engine.

Verification
REQ-036 Write addr=3 wdata=0xA5 at cycle 1 -> ready=1 in cycle 2 only; read addr=3 at cycle 3 -> rvalid=1 in cycle 5 with rdata=0xA5 (READ_LAT=2).
REQ-037 Writes on 4 consecutive cycles to addr 0..3 -> ready=1 on 4 consecutive cycles, each one cycle after its write; drop_cnt stays 0.
REQ-038 Read addr=1, then write in each of the next 2 cycles (READ_LAT=3) -> both writes refused, drop_cnt=2, mem[1] unchanged.
REQ-039 read=1 and write=1 in the same cycle -> no ready, no rvalid, err=1 and held; reset -> err=0.
REQ-040 Read accepted, reset pulsed in the RWAIT cycle -> rvalid never asserts, busy=0 immediately on reset.
REQ-041 300 commands refused during long reads -> drop_cnt saturates at 255.
